regfile: RTL and testbench

Architectural register file with rename tags, sitting between the decoder/issue stage and the reorder buffer. At issue it records which ROB entry will produce each destination register, and it resolves source operands into either a ready value or a ROB dependency tag. The resolver forwards from ROB search results and same-cycle commits. At commit it writes values from the ROB and releases tags, and it drops all tags when the ROB flushes on a mispredict.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_if.sv | 48 ++++
 rtl/regfile_resolve.sv | 46 ++++
 rtl/regfile.sv | 130 +++++++++++++
 tb/tb_regfile.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared ROB sizing constants and register-file types.
// Imported by the ROB, the register file and its operand resolver.
package regfile_pkg;

    localparam int ROB_WIDTH = 4;
    localparam int ROB_SIZE  = 1 << ROB_WIDTH;

    typedef logic [4:0]  reg_id_t;
    typedef logic [31:0] word_t;

    // x0 is hardwired, so it never takes a value write or a rename.
    function automatic logic reg_writable(input reg_id_t r);
        return (r != 5'd0);
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Issue, ROB-search and commit signals between decoder/ROB and the register file.
interface regfile_if #(
    parameter int ROB_WIDTH = regfile_pkg::ROB_WIDTH
);
    import regfile_pkg::*;

    logic                 dec_ready;
    reg_id_t              dec_rs1;
    reg_id_t              dec_rs2;
    reg_id_t              dec_rd;
    logic [ROB_WIDTH-1:0] dec_rob_id;

    word_t                rs1_val;
    word_t                rs2_val;
    logic                 rs1_dep;
    logic                 rs2_dep;
    logic [ROB_WIDTH-1:0] rs1_tag;
    logic [ROB_WIDTH-1:0] rs2_tag;

    logic [ROB_WIDTH-1:0] search_rob_id_1;
    logic [ROB_WIDTH-1:0] search_rob_id_2;
    logic                 search_ready_1;
    logic                 search_ready_2;
    word_t                search_val_1;
    word_t                search_val_2;

    logic                 commit_ready;
    logic [ROB_WIDTH-1:0] commit_rob_id;
    reg_id_t              commit_reg_id;
    word_t                commit_val;

    modport master (
        output dec_ready, dec_rs1, dec_rs2, dec_rd, dec_rob_id,
        output search_ready_1, search_ready_2, search_val_1, search_val_2,
        output commit_ready, commit_rob_id, commit_reg_id, commit_val,
        input  rs1_val, rs2_val, rs1_dep, rs2_dep, rs1_tag, rs2_tag,
        input  search_rob_id_1, search_rob_id_2
    );

    modport slave (
        input  dec_ready, dec_rs1, dec_rs2, dec_rd, dec_rob_id,
        input  search_ready_1, search_ready_2, search_val_1, search_val_2,
        input  commit_ready, commit_rob_id, commit_reg_id, commit_val,
        output rs1_val, rs2_val, rs1_dep, rs2_dep, rs1_tag, rs2_tag,
        output search_rob_id_1, search_rob_id_2
    );

endinterface

// File: rtl/regfile_resolve.sv
// Per-operand priority mux: architectural state, then same-cycle commit,
// then ROB search result, otherwise report the producing ROB tag.
module reg_operand_resolve
    import regfile_pkg::*;
#(
    parameter int ROB_WIDTH = regfile_pkg::ROB_WIDTH
) (
    input  reg_id_t              rs_i,
    input  word_t                state_val_i,
    input  logic                 state_busy_i,
    input  logic [ROB_WIDTH-1:0] state_tag_i,
    input  logic                 commit_ready_i,
    input  logic [ROB_WIDTH-1:0] commit_rob_id_i,
    input  reg_id_t              commit_reg_id_i,
    input  word_t                commit_val_i,
    input  logic                 search_ready_i,
    input  word_t                search_val_i,
    output word_t                val_o,
    output logic                 dep_o,
    output logic [ROB_WIDTH-1:0] tag_o
);

    logic commit_hit_s;

    assign commit_hit_s = commit_ready_i
                       && (commit_rob_id_i == state_tag_i)
                       && (commit_reg_id_i == rs_i);

    // Resolve the operand in forwarding priority order.
    always_comb begin
        val_o = 32'd0;
        dep_o = 1'b0;
        tag_o = {ROB_WIDTH{1'b0}};
        if ((rs_i == 5'd0) || !state_busy_i) begin
            val_o = state_val_i;
        end else if (commit_hit_s) begin
            val_o = commit_val_i;
        end else if (search_ready_i) begin
            val_o = search_val_i;
        end else begin
            dep_o = 1'b1;
            tag_o = state_tag_i;
        end
    end

endmodule

// File: rtl/regfile.sv
// Architectural register file with rename tags: records producers at issue,
// resolves operands with commit/ROB forwarding, and retires values at commit.
module regfile
    import regfile_pkg::*;
#(
    parameter int ROB_WIDTH = regfile_pkg::ROB_WIDTH
) (
    input  logic      clk_in,
    input  logic      rst_n_in,
    input  logic      rdy_in,
    input  logic      clear,
    regfile_if.slave  bus
);

    word_t                val_q  [32];
    word_t                val_d  [32];
    logic                 busy_q [32];
    logic                 busy_d [32];
    logic [ROB_WIDTH-1:0] tag_q  [32];
    logic [ROB_WIDTH-1:0] tag_d  [32];

    word_t                rs1_val_s;
    word_t                rs2_val_s;
    logic                 rs1_dep_s;
    logic                 rs2_dep_s;
    logic [ROB_WIDTH-1:0] rs1_tag_s;
    logic [ROB_WIDTH-1:0] rs2_tag_s;

    logic                 commit_en_s;
    logic                 commit_release_s;
    logic                 rename_en_s;

    assign commit_en_s      = bus.commit_ready && reg_writable(bus.commit_reg_id);
    assign commit_release_s = busy_q[bus.commit_reg_id]
                           && (tag_q[bus.commit_reg_id] == bus.commit_rob_id);
    assign rename_en_s      = bus.dec_ready && !clear && reg_writable(bus.dec_rd);

    // Next state: commit first, then clear or rename so a same-cycle rename wins.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            val_d[i]  = val_q[i];
            busy_d[i] = busy_q[i];
            tag_d[i]  = tag_q[i];
        end
        if (rdy_in) begin
            if (commit_en_s) begin
                val_d[bus.commit_reg_id] = bus.commit_val;
                if (commit_release_s) begin
                    busy_d[bus.commit_reg_id] = 1'b0;
                end else begin
                    busy_d[bus.commit_reg_id] = busy_q[bus.commit_reg_id];
                end
            end else begin
                val_d[0] = 32'd0;
            end
            if (clear) begin
                for (int i = 0; i < 32; i++) begin
                    busy_d[i] = 1'b0;
                    tag_d[i]  = {ROB_WIDTH{1'b0}};
                end
            end else if (rename_en_s) begin
                busy_d[bus.dec_rd] = 1'b1;
                tag_d[bus.dec_rd]  = bus.dec_rob_id;
            end else begin
                busy_d[0] = 1'b0;
            end
        end else begin
            tag_d[0] = {ROB_WIDTH{1'b0}};
        end
    end

    // Register array state with asynchronous clear.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 32; i++) begin
                val_q[i]  <= 32'd0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= {ROB_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                val_q[i]  <= val_d[i];
                busy_q[i] <= busy_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    reg_operand_resolve #(.ROB_WIDTH(ROB_WIDTH)) u_resolve_rs1 (
        .rs_i            (bus.dec_rs1),
        .state_val_i     (val_q[bus.dec_rs1]),
        .state_busy_i    (busy_q[bus.dec_rs1]),
        .state_tag_i     (tag_q[bus.dec_rs1]),
        .commit_ready_i  (bus.commit_ready),
        .commit_rob_id_i (bus.commit_rob_id),
        .commit_reg_id_i (bus.commit_reg_id),
        .commit_val_i    (bus.commit_val),
        .search_ready_i  (bus.search_ready_1),
        .search_val_i    (bus.search_val_1),
        .val_o           (rs1_val_s),
        .dep_o           (rs1_dep_s),
        .tag_o           (rs1_tag_s)
    );

    reg_operand_resolve #(.ROB_WIDTH(ROB_WIDTH)) u_resolve_rs2 (
        .rs_i            (bus.dec_rs2),
        .state_val_i     (val_q[bus.dec_rs2]),
        .state_busy_i    (busy_q[bus.dec_rs2]),
        .state_tag_i     (tag_q[bus.dec_rs2]),
        .commit_ready_i  (bus.commit_ready),
        .commit_rob_id_i (bus.commit_rob_id),
        .commit_reg_id_i (bus.commit_reg_id),
        .commit_val_i    (bus.commit_val),
        .search_ready_i  (bus.search_ready_2),
        .search_val_i    (bus.search_val_2),
        .val_o           (rs2_val_s),
        .dep_o           (rs2_dep_s),
        .tag_o           (rs2_tag_s)
    );

    assign bus.rs1_val         = rs1_val_s;
    assign bus.rs2_val         = rs2_val_s;
    assign bus.rs1_dep         = rs1_dep_s;
    assign bus.rs2_dep         = rs2_dep_s;
    assign bus.rs1_tag         = rs1_tag_s;
    assign bus.rs2_tag         = rs2_tag_s;
    assign bus.search_rob_id_1 = tag_q[bus.dec_rs1];
    assign bus.search_rob_id_2 = tag_q[bus.dec_rs2];

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed vector table, async reset sequence, and
// randomized traffic checked against an array-based reference model.
module tb_regfile;
    import regfile_pkg::*;

    localparam int RW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b0;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    regfile_if #(.ROB_WIDTH(RW)) bus ();

    regfile #(.ROB_WIDTH(RW)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .clear    (clr),
        .bus      (bus)
    );

    typedef struct {
        logic rdy; logic clr; logic dv;
        logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; logic [3:0] rob;
        logic s1r; logic [31:0] s1v; logic s2r; logic [31:0] s2v;
        logic cr; logic [3:0] crob; logic [4:0] creg; logic [31:0] cval;
        logic [31:0] v1; logic d1; logic [3:0] t1; logic [3:0] q1;
        logic [31:0] v2; logic d2; logic [3:0] t2; logic [3:0] q2;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t vecs [17];

    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    function automatic vec_t mkv(
        input logic [31:0] rdy_a, clr_a, dv_a, rs1_a, rs2_a, rd_a, rob_a,
        input logic [31:0] s1r_a, s1v_a, s2r_a, s2v_a,
        input logic [31:0] cr_a, crob_a, creg_a, cval_a,
        input logic [31:0] v1_a, d1_a, t1_a, q1_a, v2_a, d2_a, t2_a, q2_a);
        vec_t v;
        v.rdy = rdy_a[0];  v.clr = clr_a[0];  v.dv = dv_a[0];
        v.rs1 = rs1_a[4:0]; v.rs2 = rs2_a[4:0]; v.rd = rd_a[4:0]; v.rob = rob_a[3:0];
        v.s1r = s1r_a[0];  v.s1v = s1v_a;  v.s2r = s2r_a[0];  v.s2v = s2v_a;
        v.cr = cr_a[0]; v.crob = crob_a[3:0]; v.creg = creg_a[4:0]; v.cval = cval_a;
        v.v1 = v1_a; v.d1 = d1_a[0]; v.t1 = t1_a[3:0]; v.q1 = q1_a[3:0];
        v.v2 = v2_a; v.d2 = d2_a[0]; v.t2 = t2_a[3:0]; v.q2 = q2_a[3:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rdy                = v.rdy;
        clr                = v.clr;
        bus.dec_ready      = v.dv;
        bus.dec_rs1        = v.rs1;
        bus.dec_rs2        = v.rs2;
        bus.dec_rd         = v.rd;
        bus.dec_rob_id     = v.rob;
        bus.search_ready_1 = v.s1r;
        bus.search_val_1   = v.s1v;
        bus.search_ready_2 = v.s2r;
        bus.search_val_2   = v.s2v;
        bus.commit_ready   = v.cr;
        bus.commit_rob_id  = v.crob;
        bus.commit_reg_id  = v.creg;
        bus.commit_val     = v.cval;
    endtask

    task automatic check_vec(input string nm, input vec_t v);
        chk({nm, ".rs1_val"}, bus.rs1_val, v.v1);
        chk({nm, ".rs1_dep"}, 32'(bus.rs1_dep), 32'(v.d1));
        chk({nm, ".rs1_tag"}, 32'(bus.rs1_tag), 32'(v.t1));
        chk({nm, ".search1"}, 32'(bus.search_rob_id_1), 32'(v.q1));
        chk({nm, ".rs2_val"}, bus.rs2_val, v.v2);
        chk({nm, ".rs2_dep"}, 32'(bus.rs2_dep), 32'(v.d2));
        chk({nm, ".rs2_tag"}, 32'(bus.rs2_tag), 32'(v.t2));
        chk({nm, ".search2"}, 32'(bus.search_rob_id_2), 32'(v.q2));
    endtask

    // Reference operand: stored value, else commit forward, else search, else pending.
    task automatic model_operand(input vec_t v, input logic [4:0] r, input logic sr,
                                 input logic [31:0] sv, output logic [31:0] val,
                                 output logic dep, output logic [3:0] tag, output logic [3:0] q);
        val = 32'd0; dep = 1'b0; tag = 4'd0; q = m_tag[r];
        if (r == 5'd0 || !m_busy[r]) val = m_val[r];
        else if (v.cr && v.crob == m_tag[r] && v.creg == r) val = v.cval;
        else if (sr) val = sv;
        else begin dep = 1'b1; tag = m_tag[r]; end
    endtask

    task automatic model_step(input vec_t v);
        if (v.rdy) begin
            if (v.cr && v.creg != 5'd0) begin
                m_val[v.creg] = v.cval;
                if (m_busy[v.creg] && m_tag[v.creg] == v.crob) m_busy[v.creg] = 1'b0;
            end
            if (v.clr) begin
                for (int i = 0; i < 32; i++) begin m_busy[i] = 1'b0; m_tag[i] = 4'd0; end
            end else if (v.dv && v.rd != 5'd0) begin
                m_busy[v.rd] = 1'b1;
                m_tag[v.rd]  = v.rob;
            end
        end
    endtask

    initial begin
        vec_t v;
        //           rdy clr dv rs1 rs2 rd rob  s1r s1v  s2r s2v  cr crob creg cval      v1       d1 t1 q1  v2       d2 t2 q2
        vecs[0]  = mkv(1,0,0, 5,0,0,0, 0,0,0,0,        0,0,0,0,           0,0,0,0,          0,0,0,0);
        vecs[1]  = mkv(1,0,1, 3,0,3,2, 0,0,0,0,        0,0,0,0,           0,0,0,0,          0,0,0,0);
        vecs[2]  = mkv(1,0,0, 3,0,0,0, 0,0,0,0,        0,0,0,0,           0,1,2,2,          0,0,0,0);
        vecs[3]  = mkv(1,0,0, 3,3,0,0, 0,0,0,0,        1,2,3,'hDEAD,      'hDEAD,0,0,2,     'hDEAD,0,0,2);
        vecs[4]  = mkv(1,0,1, 3,0,7,4, 0,0,0,0,        0,0,0,0,           'hDEAD,0,0,2,     0,0,0,0);
        vecs[5]  = mkv(1,0,0, 7,7,0,0, 0,'h66,1,'h55,  0,0,0,0,           0,1,4,4,          'h55,0,0,4);
        vecs[6]  = mkv(1,0,1, 7,3,3,2, 0,0,0,0,        1,4,7,'h77,        'h77,0,0,4,       'hDEAD,0,0,2);
        vecs[7]  = mkv(1,0,1, 3,7,3,6, 0,0,0,0,        1,2,3,'h11,        'h11,0,0,2,       'h77,0,0,4);
        vecs[8]  = mkv(1,0,1, 3,3,1,1, 0,0,1,'h33,     1,2,3,'h22,        0,1,6,6,          'h33,0,0,6);
        vecs[9]  = mkv(1,0,1, 3,1,2,3, 0,0,0,0,        0,0,0,0,           0,1,6,6,          0,1,1,1);
        vecs[10] = mkv(1,0,1, 2,9,9,5, 0,0,0,0,        0,0,0,0,           0,1,3,3,          0,0,0,0);
        vecs[11] = mkv(1,1,1, 9,4,4,7, 0,0,0,0,        1,5,9,'h99,        'h99,0,0,5,       0,0,0,0);
        vecs[12] = mkv(1,0,0, 3,4,0,0, 0,0,0,0,        0,0,0,0,           'h22,0,0,0,       0,0,0,0);
        vecs[13] = mkv(1,0,0, 9,1,0,0, 0,0,0,0,        0,0,0,0,           'h99,0,0,0,       0,0,0,0);
        vecs[14] = mkv(1,0,0, 0,3,0,0, 0,0,0,0,        1,0,0,'hFF,        0,0,0,0,          'h22,0,0,0);
        vecs[15] = mkv(0,0,1, 0,3,5,3, 0,0,0,0,        1,0,5,'hAB,        0,0,0,0,          'h22,0,0,0);
        vecs[16] = mkv(1,0,0, 5,7,0,0, 0,0,0,0,        0,0,0,0,           0,0,0,0,          'h77,0,0,0);

        drive(vecs[0]);
        #3;
        check_vec("reset", vecs[0]);
        #9 rst_n = 1'b1;

        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            drive(vecs[k]);
            #1;
            check_vec($sformatf("vec%0d", k), vecs[k]);
            @(posedge clk);
        end

        // Make x3 pending, then pull reset in the middle of a cycle.
        @(negedge clk);
        drive(mkv(1,0,1, 3,9,3,6, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        @(posedge clk);
        @(negedge clk);
        drive(mkv(1,0,0, 3,9,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        #1;
        chk("pre_rst.rs1_dep", 32'(bus.rs1_dep), 32'd1);
        chk("pre_rst.rs2_val", bus.rs2_val, 32'h99);
        #2 rst_n = 1'b0;
        #1;
        check_vec("async_rst", vecs[0]);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        v = mkv(1,0,0, 5,3,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0);
        drive(v);
        #1;
        check_vec("post_rst", v);
        @(posedge clk);

        for (int i = 0; i < 32; i++) begin m_val[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = 4'd0; end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            v.rdy  = ($urandom_range(0, 9) != 0);
            v.clr  = ($urandom_range(0, 19) == 0);
            v.dv   = 1'($urandom_range(0, 1));
            v.rs1  = 5'($urandom_range(0, 7));
            v.rs2  = 5'($urandom_range(0, 7));
            v.rd   = 5'($urandom_range(0, 7));
            v.rob  = 4'($urandom_range(0, 15));
            v.s1r  = ($urandom_range(0, 3) == 0);
            v.s1v  = $urandom();
            v.s2r  = ($urandom_range(0, 3) == 0);
            v.s2v  = $urandom();
            v.cr   = 1'($urandom_range(0, 1));
            v.creg = 5'($urandom_range(0, 7));
            v.crob = ($urandom_range(0, 1) == 1) ? m_tag[v.creg] : 4'($urandom_range(0, 15));
            v.cval = $urandom();
            model_operand(v, v.rs1, v.s1r, v.s1v, v.v1, v.d1, v.t1, v.q1);
            model_operand(v, v.rs2, v.s2r, v.s2v, v.v2, v.d2, v.t2, v.q2);
            drive(v);
            #1;
            check_vec($sformatf("rnd%0d", n), v);
            @(posedge clk);
            model_step(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
